// File: rtl/qclk_trig.sv
// rtl/qclk_trig.sv - loadable free-running timebase with armable timestamp-compare trigger channels
module qclk_trig #(
  parameter int WIDTH  = 32,
  parameter int N_CHAN = 4,
  localparam int CHW   = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load_en,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  out,
  input  logic              arm_en,
  input  logic [CHW-1:0]    arm_chan,
  input  logic [WIDTH-1:0]  arm_time,
  input  logic              flush,
  output logic [N_CHAN-1:0] trig,
  output logic [N_CHAN-1:0] pending,
  output logic              busy,
  output logic              arm_err
);

  // Channel count widened by one bit so out-of-range indices can be detected
  // even when N_CHAN is an exact power of two.
  localparam logic [CHW:0] N_CHAN_W = N_CHAN[CHW:0];

  logic [WIDTH-1:0]  out_q, out_d;
  logic [WIDTH-1:0]  ts_q [N_CHAN];
  logic [WIDTH-1:0]  ts_d [N_CHAN];
  logic [N_CHAN-1:0] pending_q, pending_d;
  logic [N_CHAN-1:0] trig_q, trig_d;
  logic              arm_err_q, arm_err_d;
  logic [N_CHAN-1:0] hit;
  logic              arm_ok;

  assign arm_ok = arm_en && ({1'b0, arm_chan} < N_CHAN_W);

  // Counter next state: load beats increment, otherwise hold.
  always_comb begin
    out_d = out_q;
    if (load_en) begin
      out_d = load_val;
    end else if (enable) begin
      out_d = out_q + 1'b1;
    end
  end

  // Equality match on the registered counter and stored times; enable is not involved.
  always_comb begin
    hit = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      hit[c] = pending_q[c] && (out_q == ts_q[c]);
    end
  end

  // Channel bookkeeping: hits retire, flush clears all, a valid arm always wins for its channel.
  always_comb begin
    trig_d    = hit;
    pending_d = pending_q & ~hit;
    ts_d      = ts_q;
    arm_err_d = arm_err_q | (arm_en && !arm_ok);
    if (flush) begin
      pending_d = '0;
    end
    for (int c = 0; c < N_CHAN; c++) begin
      if (arm_ok && (arm_chan == CHW'(c))) begin
        pending_d[c] = 1'b1;
        ts_d[c]      = arm_time;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q     <= '0;
      pending_q <= '0;
      trig_q    <= '0;
      arm_err_q <= 1'b0;
      for (int c = 0; c < N_CHAN; c++) begin
        ts_q[c] <= '0;
      end
    end else begin
      out_q     <= out_d;
      pending_q <= pending_d;
      trig_q    <= trig_d;
      arm_err_q <= arm_err_d;
      for (int c = 0; c < N_CHAN; c++) begin
        ts_q[c] <= ts_d[c];
      end
    end
  end

  assign out     = out_q;
  assign trig    = trig_q;
  assign pending = pending_q;
  assign busy    = |pending_q;
  assign arm_err = arm_err_q;

endmodule

// File: tb/tb_qclk_trig.sv
// tb/tb_qclk_trig.sv - directed self-checking bench for qclk_trig
module tb_qclk_trig;

  logic       clk;
  logic       reset;
  logic       enable, load_en, arm_en, flush;
  logic [7:0] load_val, arm_time, out;
  logic [1:0] arm_chan;
  logic [3:0] trig, pending;
  logic       busy, arm_err;

  logic       enable2, load_en2, arm_en2, flush2;
  logic [7:0] load_val2, arm_time2, out2;
  logic [1:0] arm_chan2;
  logic [2:0] trig2, pending2;
  logic       busy2, arm_err2;

  int n_checks = 0;
  int n_errors = 0;

  qclk_trig #(.WIDTH(8), .N_CHAN(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load_en(load_en), .load_val(load_val),
    .out(out), .arm_en(arm_en), .arm_chan(arm_chan), .arm_time(arm_time), .flush(flush),
    .trig(trig), .pending(pending), .busy(busy), .arm_err(arm_err)
  );

  qclk_trig #(.WIDTH(8), .N_CHAN(3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable2), .load_en(load_en2), .load_val(load_val2),
    .out(out2), .arm_en(arm_en2), .arm_chan(arm_chan2), .arm_time(arm_time2), .flush(flush2),
    .trig(trig2), .pending(pending2), .busy(busy2), .arm_err(arm_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_out(input logic [7:0] v, input int budget);
    int n = 0;
    while (out !== v && n < budget) begin
      tick();
      n++;
    end
    check("wait_out", {24'd0, out}, {24'd0, v});
  endtask

  task automatic load(input logic [7:0] v);
    load_en = 1'b1; load_val = v;
    tick();
    load_en = 1'b0;
  endtask

  task automatic arm(input logic [1:0] ch, input logic [7:0] t);
    arm_en = 1'b1; arm_chan = ch; arm_time = t;
    tick();
    arm_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    enable = 0; load_en = 0; arm_en = 0; flush = 0;
    load_val = 0; arm_time = 0; arm_chan = 0;
    enable2 = 0; load_en2 = 0; arm_en2 = 0; flush2 = 0;
    load_val2 = 0; arm_time2 = 0; arm_chan2 = 0;
    tick(); tick();
    check("rst_out", {24'd0, out}, 32'd0);
    check("rst_trig", {28'd0, trig}, 32'd0);
    check("rst_pend", {28'd0, pending}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, arm_err}, 32'd0);
    reset = 1'b1;
    check("rel_out", {24'd0, out}, 32'd0);

    // 1: counting, hold, load and wrap
    enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("count", {24'd0, out}, i);
    end
    enable = 1'b0;
    tick(); tick(); tick();
    check("hold", {24'd0, out}, 32'd10);
    load(8'hFE);
    check("load_fe", {24'd0, out}, 32'hFE);
    enable = 1'b1;
    tick(); check("wrap_ff", {24'd0, out}, 32'hFF);
    tick(); check("wrap_00", {24'd0, out}, 32'h00);
    tick(); check("wrap_01", {24'd0, out}, 32'h01);

    // 2: single channel fire
    enable = 1'b0;
    load(8'd5);
    arm(2'd2, 8'd20);
    check("t2_pend", {28'd0, pending}, 32'b0100);
    check("t2_busy", {31'd0, busy}, 32'd1);
    enable = 1'b1;
    wait_out(8'd20, 40);
    check("t2_pre", {28'd0, trig}, 32'd0);
    tick();
    check("t2_trig", {28'd0, trig}, 32'b0100);
    check("t2_pend0", {28'd0, pending}, 32'd0);
    tick();
    check("t2_trig_off", {28'd0, trig}, 32'd0);

    // 3: simultaneous channels and a later one
    enable = 1'b0;
    load(8'd25);
    arm(2'd0, 8'd30);
    arm(2'd1, 8'd30);
    arm(2'd3, 8'd40);
    check("t3_pend", {28'd0, pending}, 32'b1011);
    enable = 1'b1;
    wait_out(8'd30, 20);
    tick();
    check("t3_trig01", {28'd0, trig}, 32'b0011);
    for (int i = 0; i < 9; i++) tick();
    check("t3_out40", {24'd0, out}, 32'd40);
    check("t3_gap", {28'd0, trig}, 32'd0);
    check("t3_busy1", {31'd0, busy}, 32'd1);
    tick();
    check("t3_trig3", {28'd0, trig}, 32'b1000);
    check("t3_busy0", {31'd0, busy}, 32'd0);

    // 4: skipped by load, later hit, re-arm at the hit edge
    enable = 1'b0;
    load(8'd40);
    arm(2'd1, 8'd50);
    load(8'd60);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_skip", {28'd0, trig}, 32'd0);
    end
    check("t4_pend", {28'd0, pending}, 32'b0010);
    enable = 1'b0;
    load(8'd45);
    enable = 1'b1;
    wait_out(8'd50, 20);
    arm(2'd1, 8'd55);
    check("t4_trig50", {28'd0, trig}, 32'b0010);
    check("t4_rearm", {28'd0, pending}, 32'b0010);
    wait_out(8'd55, 20);
    check("t4_pre55", {28'd0, trig}, 32'd0);
    tick();
    check("t4_trig55", {28'd0, trig}, 32'b0010);
    check("t4_pend0", {28'd0, pending}, 32'd0);

    // 5: flush, flush+arm, arm at current time, out-of-range arm
    enable = 1'b0;
    load(8'd85);
    arm(2'd0, 8'd100);
    arm(2'd2, 8'd100);
    check("t5_pend", {28'd0, pending}, 32'b0101);
    enable = 1'b1;
    wait_out(8'd90, 20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_flush", {28'd0, pending}, 32'd0);
    wait_out(8'd100, 20);
    tick();
    check("t5_nofire", {28'd0, trig}, 32'd0);
    enable = 1'b0;
    arm(2'd0, 8'd200);
    flush = 1'b1;
    arm(2'd3, 8'd210);
    flush = 1'b0;
    check("t5_flush_arm", {28'd0, pending}, 32'b1000);
    flush = 1'b1; tick(); flush = 1'b0;
    arm(2'd0, out);
    check("t5_now_trig0", {28'd0, trig}, 32'd0);
    tick();
    check("t5_now_trig", {28'd0, trig}, 32'b0001);
    check("t5_err_main", {31'd0, arm_err}, 32'd0);

    arm_en2 = 1'b1; arm_chan2 = 2'd0; arm_time2 = 8'd7;
    tick();
    arm_chan2 = 2'd3; arm_time2 = 8'd9;
    tick();
    arm_en2 = 1'b0;
    check("t5_err", {31'd0, arm_err2}, 32'd1);
    check("t5_err_pend", {29'd0, pending2}, 32'b001);
    arm_en2 = 1'b1; arm_chan2 = 2'd1; arm_time2 = 8'd8;
    tick();
    arm_en2 = 1'b0;
    check("t5_err_sticky", {31'd0, arm_err2}, 32'd1);
    check("t5_pend2", {29'd0, pending2}, 32'b011);

    // 6: reset mid-operation, then re-arm
    enable = 1'b0;
    load(8'd10);
    arm(2'd3, 8'd20);
    enable = 1'b1;
    wait_out(8'd19, 20);
    reset = 1'b0;
    #1;
    check("t6_out", {24'd0, out}, 32'd0);
    check("t6_pend", {28'd0, pending}, 32'd0);
    check("t6_err2", {31'd0, arm_err2}, 32'd0);
    enable = 1'b0;
    tick(); tick();
    check("t6_trig", {28'd0, trig}, 32'd0);
    reset = 1'b1;
    tick();
    check("t6_trig_rel", {28'd0, trig}, 32'd0);
    arm(2'd3, 8'd3);
    check("t6_arm", {28'd0, pending}, 32'b1000);
    enable = 1'b1;
    wait_out(8'd3, 10);
    tick();
    check("t6_fire", {28'd0, trig}, 32'b1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
